// File: rtl/regfile_wr_arbiter_if.sv
// Core-writeback and debug-write request bundle for regfile_wr_arbiter.
// The master side is the requester (core datapath / debug module). The slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            core_we;
  logic [AW-1:0]   core_addr;
  logic [XLEN-1:0] core_wdata;
  logic            core_stall;

  logic            dbg_valid;
  logic            dbg_ready;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_wdata;

  modport master (
    output core_we, core_addr, core_wdata,
    input  core_stall,
    output dbg_valid, dbg_addr, dbg_wdata,
    input  dbg_ready
  );

  modport slave (
    input  core_we, core_addr, core_wdata,
    output core_stall,
    input  dbg_valid, dbg_addr, dbg_wdata,
    output dbg_ready
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: core has priority, debug has a 1-entry buffer plus a starvation guard.
// Define RFARB_CLEAR_EN to add the post-reset zero-fill of x1..x31 before the core is released.
module regfile_wr_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wr_arbiter_if.slave   bus,
  output logic                  init_done,
  output logic                  WE,
  output logic [AW-1:0]         A3,
  output logic [XLEN-1:0]       WD3
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic            in_clear;
  logic [AW-1:0]   clear_addr;

  logic            hold_valid;
  logic [AW-1:0]   hold_addr;
  logic [XLEN-1:0] hold_data;
  logic [7:0]      starve_cnt;

  logic            core_busy;
  logic            force_dbg;
  logic            drain;
  logic            starve_inc;
  logic            capture;
  logic            stall;
  logic            ready;

`ifdef RFARB_CLEAR_EN
  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

  state_t        state, state_next;
  logic [AW-1:0] clr_cnt, clr_cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= AW'(1);
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      S_CLEAR: begin
        clr_cnt_next = clr_cnt + AW'(1);
        if (clr_cnt == LAST_REG) state_next = S_RUN;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  assign in_clear   = (state == S_CLEAR);
  assign clear_addr = clr_cnt;
`else
  assign in_clear   = 1'b0;
  assign clear_addr = '0;
`endif

  // A core write to x0 is architecturally a no-op, so it leaves the port free for the debug entry.
  assign core_busy = bus.core_we && (bus.core_addr != '0);
  assign force_dbg = hold_valid && (starve_cnt == STARVE_LIM);

  // NOTE: every combinationally driven signal gets a default first, so no path can infer a latch.
  always_comb begin
    WE         = 1'b0;
    A3         = '0;
    WD3        = '0;
    stall      = 1'b1;
    ready      = 1'b0;
    drain      = 1'b0;
    starve_inc = 1'b0;
    if (!rst) begin
      if (in_clear) begin
        WE = 1'b1;
        A3 = clear_addr;
      end else begin
        stall = 1'b0;
        ready = !hold_valid;
        if (force_dbg) begin
          WE    = 1'b1;
          A3    = hold_addr;
          WD3   = hold_data;
          stall = 1'b1;
          drain = 1'b1;
        end else if (core_busy) begin
          WE         = 1'b1;
          A3         = bus.core_addr;
          WD3        = bus.core_wdata;
          starve_inc = hold_valid;
        end else if (hold_valid) begin
          WE    = 1'b1;
          A3    = hold_addr;
          WD3   = hold_data;
          drain = 1'b1;
        end
      end
    end
  end

  assign bus.core_stall = stall;
  assign bus.dbg_ready  = ready;
  assign init_done      = !rst && !in_clear;
  assign capture        = bus.dbg_valid && ready;

  // A buffer drained this cycle is still not ready, so capture and drain never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (drain) begin
        hold_valid <= 1'b0;
        starve_cnt <= '0;
      end else if (starve_inc && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      if (capture && (bus.dbg_addr != '0)) hold_valid <= 1'b1;
    end
  end

  // NOTE: the payload registers need no reset; hold_valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (capture) begin
      hold_addr <= bus.dbg_addr;
      hold_data <= bus.dbg_wdata;
    end
  end

  a_no_x0_write: assert property (@(posedge clk) disable iff (rst) WE |-> (A3 != '0));
  a_force_stalls: assert property (@(posedge clk) disable iff (rst) force_dbg |-> stall);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: reset/clear, vector table, starvation, reset corners, random vs model.
// Compile with or without RFARB_CLEAR_EN to match the RTL build.
module tb_regfile_wr_arbiter;
  localparam int XLEN   = 32;
  localparam int AW     = 5;
  localparam int STARVE = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            init_done;
  logic            WE;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;

  int n_checks = 0;
  int n_err    = 0;

  regfile_wr_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wr_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(STARVE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_done (init_done),
    .WE        (WE),
    .A3        (A3),
    .WD3       (WD3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            cwe;
    logic [AW-1:0]   caddr;
    logic [XLEN-1:0] cdata;
    logic            dv;
    logic [AW-1:0]   daddr;
    logic [XLEN-1:0] ddata;
    logic            ewe;
    logic [AW-1:0]   ea3;
    logic [XLEN-1:0] ewd;
    logic            estall;
    logic            eready;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic apply(input logic cwe, input logic [AW-1:0] caddr, input logic [XLEN-1:0] cdata,
                       input logic dv, input logic [AW-1:0] daddr, input logic [XLEN-1:0] ddata);
    @(negedge clk);
    rst            = 1'b0;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cdata;
    bus.dbg_valid  = dv;
    bus.dbg_addr   = daddr;
    bus.dbg_wdata  = ddata;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst            = 1'b1;
      bus.core_we    = 1'b1;
      bus.core_addr  = 5'd9;
      bus.core_wdata = 32'hFFFF_FFFF;
      bus.dbg_valid  = 1'b1;
      bus.dbg_addr   = 5'd10;
      bus.dbg_wdata  = 32'h1;
      #1;
      check("rst_port", {WE, A3, WD3}, '0);
      check("rst_ctl", {bus.core_stall, bus.dbg_ready, init_done}, 3'b100);
    end
  endtask

  // Walks the clear sequence from A3=first; core and debug requests are held active to show they are ignored.
  task automatic run_clear(input int first);
`ifdef RFARB_CLEAR_EN
    logic [31:0] seen;
    seen = '0;
    for (int i = first; i <= 31; i++) begin
      apply(1'b1, 5'd5, 32'hAAAA_AAAA, 1'b1, 5'd6, 32'h5555);
      check("clr_port", {WE, A3, WD3}, {1'b1, 5'(i), 32'h0});
      check("clr_ctl", {bus.core_stall, bus.dbg_ready, init_done}, 3'b100);
      if (WE === 1'b1 && WD3 === '0) seen[A3] = 1'b1;
    end
    if (first == 1) check("clr_all_zeroed", {32'h0, seen}, {32'h0, 32'hFFFF_FFFE});
`else
    if (first < 0) $display("unused");
`endif
  endtask

  initial begin
    bit              p_valid;
    int              p_since;
    logic [AW-1:0]   p_addr;
    logic [XLEN-1:0] p_data;
    logic            e_we, e_stall, e_ready, drained;
    logic [AW-1:0]   e_a3;
    logic [XLEN-1:0] e_wd;
    logic            r_cwe, r_dv;
    logic [AW-1:0]   r_caddr, r_daddr;
    logic [XLEN-1:0] r_cdata, r_ddata;
    int              busy_pct;

    bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    // Reset, clear (if built in), then a core write on the very first RUN cycle.
    do_reset(2);
    run_clear(1);
    apply(1'b1, 5'd3, 32'h3333_0003, 1'b0, '0, '0);
    check("first_run_port", {WE, A3, WD3}, {1'b1, 5'd3, 32'h3333_0003});
    check("first_run_ctl", {bus.core_stall, bus.dbg_ready, init_done}, 3'b011);

    // Directed vectors: core priority, x0 handling, drain timing.
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'h1234,     1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h77,   1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hA5,   1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[7]  = '{1'b1, 5'd0, 32'hFF,       1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hA5,       1'b0, 1'b0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    vecs[9]  = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd4, 32'h44,   1'b1, 5'd3, 32'h33,       1'b0, 1'b1};
    vecs[10] = '{1'b1, 5'd3, 32'h34,       1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h34,       1'b0, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h44,       1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,        1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].cwe, vecs[i].caddr, vecs[i].cdata, vecs[i].dv, vecs[i].daddr, vecs[i].ddata);
      check($sformatf("vec%0d_port", i), {WE, A3, WD3}, {vecs[i].ewe, vecs[i].ea3, vecs[i].ewd});
      check($sformatf("vec%0d_ctl", i), {bus.core_stall, bus.dbg_ready, init_done},
            {vecs[i].estall, vecs[i].eready, 1'b1});
    end

    // Starvation: 8 core writes, then the debug entry is forced in with a stall, then the core resumes.
    apply(1'b0, '0, '0, 1'b1, 5'd12, 32'hCAFE);
    check("starve_accept", {WE, bus.dbg_ready}, 2'b01);
    for (int k = 0; k < STARVE; k++) begin
      apply(1'b1, 5'd7, 32'(k), 1'b0, '0, '0);
      check($sformatf("starve_core%0d", k), {WE, A3, WD3, bus.core_stall}, {1'b1, 5'd7, 32'(k), 1'b0});
    end
    apply(1'b1, 5'd7, 32'd8, 1'b0, '0, '0);
    check("starve_force_port", {WE, A3, WD3}, {1'b1, 5'd12, 32'hCAFE});
    check("starve_force_stall", {bus.core_stall, bus.dbg_ready}, 2'b10);
    apply(1'b1, 5'd7, 32'd9, 1'b0, '0, '0);
    check("starve_resume", {WE, A3, WD3, bus.core_stall, bus.dbg_ready}, {1'b1, 5'd7, 32'd9, 1'b0, 1'b1});

    // Reset with an entry pending: it must never reach the port.
    apply(1'b0, '0, '0, 1'b1, 5'd20, 32'hBEEF);
    do_reset(1);
    run_clear(1);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("post_rst_no_dbg", {WE, bus.dbg_ready, init_done}, 3'b011);
    end

`ifdef RFARB_CLEAR_EN
    // Reset mid-clear at cnt=17: the sequence restarts at x1.
    do_reset(1);
    for (int i = 1; i <= 16; i++) begin
      apply(1'b0, '0, '0, 1'b0, '0, '0);
      check("midclr_port", {WE, A3}, {1'b1, 5'(i)});
    end
    do_reset(1);
    run_clear(1);
    idle();
    check("midclr_done", {init_done, bus.core_stall}, 2'b10);
`endif

    // Random traffic against a deadline model: a pending entry is forced exactly STARVE cycles after it
    // first becomes pending, since every intervening cycle must have been taken by the core.
    p_valid = 1'b0; p_since = 0; p_addr = '0; p_data = '0;
    for (int c = 0; c < 800; c++) begin
      busy_pct = ((c / 100) % 2 == 1) ? 97 : 50;
      r_cwe   = ($urandom_range(0, 99) < busy_pct);
      r_caddr = 5'($urandom_range(0, 31));
      r_cdata = $urandom;
      r_dv    = ($urandom_range(0, 1) == 1);
      r_daddr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_ddata = $urandom;
      apply(r_cwe, r_caddr, r_cdata, r_dv, r_daddr, r_ddata);

      e_ready = !p_valid; e_stall = 1'b0; drained = 1'b0;
      e_we = 1'b0; e_a3 = '0; e_wd = '0;
      if (p_valid && (c - p_since == STARVE)) begin
        e_we = 1'b1; e_a3 = p_addr; e_wd = p_data; e_stall = 1'b1; drained = 1'b1;
      end else if (r_cwe && r_caddr != 0) begin
        e_we = 1'b1; e_a3 = r_caddr; e_wd = r_cdata;
      end else if (p_valid) begin
        e_we = 1'b1; e_a3 = p_addr; e_wd = p_data; drained = 1'b1;
      end
      check($sformatf("rnd%0d_port", c), {WE, A3, WD3}, {e_we, e_a3, e_wd});
      check($sformatf("rnd%0d_ctl", c), {bus.core_stall, bus.dbg_ready, init_done}, {e_stall, e_ready, 1'b1});

      if (drained) p_valid = 1'b0;
      if (r_dv && e_ready && r_daddr != 0) begin
        p_valid = 1'b1; p_since = c + 1; p_addr = r_daddr; p_data = r_ddata;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
